// File: rtl/fp8_pkg.sv
// Shared FP8/FP32 format constants for the FP8 pack/unpack datapath.
package fp8_pkg;

    localparam int unsigned E4M3_E = 4;
    localparam int unsigned E4M3_M = 3;
    localparam int unsigned E5M2_E = 5;
    localparam int unsigned E5M2_M = 2;

    localparam int unsigned F32_W     = 32;
    localparam int unsigned F32_MAN_W = 23;
    localparam int unsigned F32_BIAS  = 127;

    localparam logic [7:0]  F32_INF_EXP = 8'hFF;
    localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;

endpackage

// File: rtl/float8_unpack_lane.sv
// Combinational single-byte FP8 -> FP32 widener; exact for E <= 5.
module float8_unpack_lane
    import fp8_pkg::*;
#(
    parameter int unsigned E    = E4M3_E,
    parameter int unsigned M    = E4M3_M,
    parameter int unsigned BIAS = (1 << (E - 1)) - 1
) (
    input  logic [E+M:0]      fp8,
    output logic [F32_W-1:0]  f32_c,
    output logic              special_c
);

    logic               sgn;
    logic [E-1:0]       ex;
    logic [M-1:0]       man;
    logic [7:0]         shift;
    logic [M-1:0]       man_sub;
    logic signed [9:0]  exp_w;

    assign {sgn, ex, man} = fp8;

    // Leading-one detect: shift = M - p, and the fraction bits below the leading one left-justified.
    always_comb begin
        shift = 8'(M);
        for (int i = 0; i < int'(M); i++) begin
            if (man[i]) begin
                shift = 8'(int'(M) - i);
            end
        end
        man_sub = man << shift;
    end

    // Classify the byte and assemble the FP32 word.
    always_comb begin
        exp_w     = '0;
        f32_c     = '0;
        special_c = 1'b0;
        if (ex == '1) begin
            special_c = 1'b1;
            if (man == '0) begin
                f32_c = {sgn, F32_INF_EXP, {F32_MAN_W{1'b0}}};
            end else begin
                f32_c = {sgn, F32_QNAN[30:0]};
            end
        end else if (ex == '0) begin
            if (man == '0) begin
                f32_c = {sgn, 31'b0};
            end else begin
                exp_w = $signed(10'(F32_BIAS + 1)) - $signed(10'(BIAS)) - $signed(10'(shift));
                f32_c = {sgn, 8'(exp_w), man_sub, {(F32_MAN_W - M){1'b0}}};
            end
        end else begin
            exp_w = $signed(10'(ex)) - $signed(10'(BIAS)) + $signed(10'(F32_BIAS));
            f32_c = {sgn, 8'(exp_w), man, {(F32_MAN_W - M){1'b0}}};
        end
    end

endmodule

// File: rtl/float8_unpack_stream.sv
// Streaming FP8 word -> FP32 scalar widener with valid/ready on both sides.
module float8_unpack_stream
    import fp8_pkg::*;
#(
    parameter int unsigned E     = E4M3_E,
    parameter int unsigned M     = E4M3_M,
    parameter int unsigned BIAS  = (1 << (E - 1)) - 1,
    parameter int unsigned LANES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [LANES*(1+E+M)-1:0]        in_data_i,
    input  logic [$clog2(LANES)-1:0]        in_cnt_i,
    input  logic                            in_last_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [F32_W-1:0]                out_f32_o,
    output logic                            out_last_o,
    output logic                            out_special_o
);

    localparam int unsigned W  = 1 + E + M;
    localparam int unsigned DW = LANES * W;
    localparam int unsigned CW = $clog2(LANES);

    logic [DW-1:0]    hold_data, hold_data_d;
    logic [CW-1:0]    hold_cnt, hold_cnt_d;
    logic             hold_last, hold_last_d;
    logic             hold_valid, hold_valid_d;
    logic [CW-1:0]    lane, lane_d;
    logic             out_valid_d, out_last_d, out_special_d;
    logic [F32_W-1:0] out_f32_d;

    logic             adv, last_lane, load;
    logic [CW-1:0]    cnt_clamped;
    logic [W-1:0]     sel;
    logic [F32_W-1:0] f32_c;
    logic             special_c;

    assign adv        = hold_valid & (~out_valid_o | out_ready_i);
    assign last_lane  = (lane == hold_cnt);
    assign in_ready_o = ~hold_valid | (adv & last_lane);
    assign load       = in_valid_i & in_ready_o;

    assign cnt_clamped = (32'(in_cnt_i) >= LANES - 1) ? CW'(LANES - 1) : in_cnt_i;

    // Lane mux feeding the single converter.
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (lane == CW'(i)) begin
                sel = hold_data[i*W +: W];
            end
        end
    end

    float8_unpack_lane #(
        .E    (E),
        .M    (M),
        .BIAS (BIAS)
    ) u_lane (
        .fp8       (sel),
        .f32_c     (f32_c),
        .special_c (special_c)
    );

    // Next-state: hold stage, lane counter and output register.
    always_comb begin
        hold_data_d   = hold_data;
        hold_cnt_d    = hold_cnt;
        hold_last_d   = hold_last;
        hold_valid_d  = hold_valid;
        lane_d        = lane;
        out_valid_d   = out_valid_o;
        out_f32_d     = out_f32_o;
        out_last_d    = out_last_o;
        out_special_d = out_special_o;

        if (adv) begin
            if (last_lane) begin
                hold_valid_d = 1'b0;
            end else begin
                lane_d = lane + CW'(1);
            end
        end

        // A same-cycle accept overrides the clear on the final lane.
        if (load) begin
            hold_data_d  = in_data_i;
            hold_cnt_d   = cnt_clamped;
            hold_last_d  = in_last_i;
            hold_valid_d = 1'b1;
            lane_d       = '0;
        end

        if (adv) begin
            out_valid_d   = 1'b1;
            out_f32_d     = f32_c;
            out_last_d    = hold_last & last_lane;
            out_special_d = special_c;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_data     <= '0;
            hold_cnt      <= '0;
            hold_last     <= 1'b0;
            hold_valid    <= 1'b0;
            lane          <= '0;
            out_valid_o   <= 1'b0;
            out_f32_o     <= '0;
            out_last_o    <= 1'b0;
            out_special_o <= 1'b0;
        end else begin
            hold_data     <= hold_data_d;
            hold_cnt      <= hold_cnt_d;
            hold_last     <= hold_last_d;
            hold_valid    <= hold_valid_d;
            lane          <= lane_d;
            out_valid_o   <= out_valid_d;
            out_f32_o     <= out_f32_d;
            out_last_o    <= out_last_d;
            out_special_o <= out_special_d;
        end
    end

endmodule

// File: doc/float8_unpack_stream.md
# float8_unpack_stream

Streaming FP8 → FP32 widener: accepts words of `LANES` packed FP8 values over a valid/ready handshake and emits one IEEE-754 float32 per cycle. It is the read-side counterpart of the FP8 packer and decodes the same IEEE-style format (all-ones exponent reserved for Inf/NaN, bias `2^(E-1)-1`). It sits between FP8 operand memory and the FP32 datapath feeding the systolic array. Every conversion is exact: FP8 ⊂ FP32, so no rounding and no saturation occur.

## Interface
Parameters:
- `E`, 4: FP8 exponent width. E5M2 is `E=5, M=2`.
- `M`, 3: FP8 mantissa width.
- `BIAS`, `(1<<(E-1))-1`: FP8 exponent bias.
- `LANES`, 4: FP8 values per input word.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  input word valid.
- `in_ready_o`  out  1  input word accepted when `in_valid_i & in_ready_o`.
- `in_data_i`  in  `LANES*(1+E+M)`  packed FP8 values; lane 0 occupies the LSBs.
- `in_cnt_i`  in  `$clog2(LANES)`  number of valid lanes minus 1.
- `in_last_i`  in  1  last word of a tensor row.
- `out_valid_o`  out  1  FP32 result valid.
- `out_ready_i`  in  1  downstream accepts the result.
- `out_f32_o`  out  32  FP32 bits.
- `out_last_o`  out  1  final lane of a word that had `in_last_i`.
- `out_special_o`  out  1  result is Inf or NaN.

## Operation
- Hold stage: registers `hold_data`, `hold_cnt`, `hold_last`, `hold_valid`, plus lane counter `lane` (starts at 0).
- Load rule: word loads when `in_valid_i & in_ready_o`. Load sets `lane=0` and `hold_valid=1`.
- Output register update: the output register updates when `adv = hold_valid & (~out_valid_o | out_ready_i)`. On `adv` it captures the conversion of byte `hold_data[lane]`.
- Lane counter on `adv`:
  - If `lane==hold_cnt`, clear `hold_valid` (or reload it if a new word is accepted the same cycle).
  - Otherwise, `lane+1`.
- `in_ready_o = ~hold_valid | (adv & lane==hold_cnt)`. This allows back-to-back words without a bubble.
- When `~adv & out_ready_i`, `out_valid_o` clears.
- Output register holds stable while `out_valid_o & ~out_ready_i`.
- Lane count: `in_cnt_i` values of `LANES-1` or more are treated as `LANES-1`. Lanes above `hold_cnt` are never emitted.
- Flags:
  - `out_last_o = hold_last & (lane==hold_cnt)`, registered with the data.
  - `out_special_o` is high when `exp==all-ones`.
- Conversion of a byte `{s, e, m}`:
  - Zero (`e==0, m==0`): `{s, 31'b0}`.
  - Inf (`e==all-ones, m==0`): `{s, 8'hFF, 23'b0}`.
  - NaN (`e==all-ones, m!=0`): `{s, 8'hFF, 1'b1, 22'b0}` (quiet; payload dropped).
  - Normal: exponent `e - BIAS + 127`, mantissa `{m, (23-M)'b0}`.
  - Subnormal (`e==0, m!=0`): let `p` be the index of the leading one of `m`.
    - Exponent: `127 + 1 - BIAS - (M - p)`.
    - Mantissa: bits of `m` below `p`, left-justified into 23 bits.
  - Exponent arithmetic uses a 10-bit signed intermediate. All results are in range for E ≤ 5.

## Timing
- Reset values: `in_ready_o=1`, `out_valid_o=0`, `out_f32_o=0`, `out_last_o=0`, `out_special_o=0`; `hold_valid=0`, `lane=0`.
- Reset mid-word drops all buffered lanes; nothing partial is emitted after reset.
- Latency: word accepted at edge t → lane 0 on `out_valid_o` at edge t+1 (visible in cycle t+1 → t+2), given `out_ready_i=1`.
- Throughput: one FP32 per cycle while the downstream is ready. A full word of `LANES` lanes takes `LANES` cycles. `in_ready_o` is high in one cycle per word.
- Backpressure: no output is lost or duplicated. `out_*` stay constant while stalled.
- `in_ready_o` depends combinationally on `out_ready_i`. This is the only combinational input-to-output path.

## Structure
- Shared package `fp8_pkg`: format localparams `E4M3_E/M`, `E5M2_E/M`, FP32 constants `F32_QNAN`, `F32_INF_EXP`.
- Sub-module `float8_unpack_lane`: purely combinational single-byte FP8 → FP32 converter with a leading-one detector, parameterised by `E`, `M`, `BIAS`. It is instantiated once and fed by a lane mux.
- The top level holds the handshake, lane counter and output register.

## Test plan
- Reset, then word `{0x80,0xC0,0x38,0x00}`, `cnt=3`, `out_ready_i=1` → outputs in lane order 0x00000000, 0x3F800000, 0xC0000000, 0x80000000.
- Subnormals/limits (E4M3) → exact results:
  - 0x01 → 0x3B000000
  - 0x07 → 0x3C600000
  - 0x08 → 0x3C800000
  - 0x77 → 0x43700000
  - 0x7F → 0x7FC00000 with special=1
  - 0xF8 → 0xFF800000 with special=1
- E5M2 instance: 0x3C → 0x3F800000; 0x01 → 0x37800000; 0x7B → 0x47600000.
- Two back-to-back words with `cnt=3` and `in_last_i` set on the second → 8 consecutive valid cycles, no bubble; `out_last_o` only on the 8th.
- Random `out_ready_i` (50%) over 100 words → the output sequence matches the reference model exactly, and data is stable during stalls.
- Words with `cnt=1`, plus assertion of `rst_i` after the 2nd lane of a 4-lane word → only 2 lanes per short word; no output after reset until a new accept; all outputs are at reset values the cycle after reset.
